alu_sequencer: RTL

Upstream control stage for the 16-bit ALU. Accepts 8-bit register-to-register instructions over a valid/ready handshake. Holds a 4 x 16-bit register file, drives the ALU operand and opcode inputs from registered state, and captures the ALU's combinational result. It writes the result back to the destination register and presents it downstream with a valid/ready handshake, a zero flag and a completed-operation counter.

---
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Handshake and ALU-facing bus of the ALU sequencer: instruction channel,
// direct register load, ALU operand/result wires and the result channel.
interface alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [15:0] alu_rout;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zero;
    logic [15:0] op_count;

    // Sequencer side: consumes instructions and loads, produces ALU inputs and results.
    modport slave (
        input  instr_valid, instr, ld_en, ld_addr, ld_data, alu_rout, res_ready,
        output instr_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_zero, op_count
    );

    // Environment side: issues instructions, models the ALU, consumes results.
    modport master (
        output instr_valid, instr, ld_en, ld_addr, ld_data, alu_rout, res_ready,
        input  instr_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_zero, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Control stage for the 16-bit ALU: 4x16 register file, registered operand
// drive, one-cycle execute, and a held result with valid/ready handshake.
module alu_sequencer (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        accept_s;
    logic        exec_s;
    logic        consume_s;

    logic [1:0]  op_f_s;
    logic [1:0]  rd_f_s;
    logic [1:0]  rs_f_s;
    logic [1:0]  rt_f_s;

    logic [15:0] rf_r [4];
    logic [3:0]  wb_sel_s;
    logic [3:0]  ld_sel_s;

    logic [15:0] alu_a_r;
    logic [15:0] alu_b_r;
    logic [1:0]  alu_op_r;
    logic [1:0]  rd_r;

    logic        res_valid_r;
    logic [15:0] res_data_r;
    logic        res_zero_r;
    logic [15:0] op_count_r;

    function automatic logic is_zero16(input logic [15:0] v);
        return (v == 16'h0000);
    endfunction

    // Split the instruction word into its fields.
    always_comb begin
        op_f_s = bus.instr[7:6];
        rd_f_s = bus.instr[5:4];
        rs_f_s = bus.instr[3:2];
        rt_f_s = bus.instr[1:0];
    end

    // Next-state and per-state control strobes.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        exec_s    = 1'b0;
        consume_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.instr_valid) begin
                    accept_s = 1'b1;
                    state_s  = EXEC;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC: begin
                exec_s  = 1'b1;
                state_s = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    consume_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Register-file write selects; a writeback masks a load to the same register.
    always_comb begin
        wb_sel_s = 4'b0000;
        ld_sel_s = 4'b0000;
        if (exec_s) begin
            wb_sel_s[rd_r] = 1'b1;
        end else begin
            wb_sel_s = 4'b0000;
        end
        if (bus.ld_en) begin
            ld_sel_s[bus.ld_addr] = 1'b1;
        end else begin
            ld_sel_s = 4'b0000;
        end
        ld_sel_s = ld_sel_s & ~wb_sel_s;
    end

    // Register file storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_s[i]) begin
                    rf_r[i] <= bus.alu_rout;
                end else if (ld_sel_s[i]) begin
                    rf_r[i] <= bus.ld_data;
                end
            end
        end
    end

    // Operand capture at accept; values hold until the next accepted instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r  <= 16'h0000;
            alu_b_r  <= 16'h0000;
            alu_op_r <= 2'b00;
            rd_r     <= 2'b00;
        end else if (accept_s) begin
            alu_a_r  <= rf_r[rs_f_s];
            alu_b_r  <= rf_r[rt_f_s];
            alu_op_r <= op_f_s;
            rd_r     <= rd_f_s;
        end
    end

    // Result capture, result handshake and completed-operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 16'h0000;
            res_zero_r  <= 1'b0;
            op_count_r  <= 16'h0000;
        end else begin
            if (exec_s) begin
                res_valid_r <= 1'b1;
                res_data_r  <= bus.alu_rout;
                res_zero_r  <= is_zero16(bus.alu_rout);
            end else if (consume_s) begin
                res_valid_r <= 1'b0;
            end
            if (consume_s) begin
                op_count_r <= op_count_r + 16'h0001;
            end
        end
    end

    assign bus.instr_ready = (state_r == IDLE);
    assign bus.alu_a       = alu_a_r;
    assign bus.alu_b       = alu_b_r;
    assign bus.alu_op      = alu_op_r;
    assign bus.res_valid   = res_valid_r;
    assign bus.res_data    = res_data_r;
    assign bus.res_zero    = res_zero_r;
    assign bus.op_count    = op_count_r;

endmodule
